alu_exec: RTL and testbench

- Execute stage directly downstream of the 8x16 general purpose register file.
- Consumes the SR1/SR2 read data plus decoded control.
- Produces a registered result for the bus/writeback path and maintains the N/Z/P condition-code register.
- ADD/AND/NOT complete in one cycle; optional MUL is a multi-cycle shift-add unit behind a start/busy/valid handshake.

---
 rtl/alu_exec_if.sv | 29 ++
 rtl/alu_exec.sv | 141 ++++++++++++++
 tb/tb_alu_exec.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Operand/control request and result/condition-code response bundle for alu_exec.
// The master drives requests; the slave (alu_exec) returns result, handshake and N/Z/P.
interface alu_exec_if #(
    parameter int unsigned N = 16
);
    logic         start;
    logic [1:0]   op;
    logic         imm_sel;
    logic [4:0]   imm5;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ld_cc;
    logic [N-1:0] result;
    logic         valid;
    logic         busy;
    logic         n;
    logic         z;
    logic         p;

    modport master (
        output start, op, imm_sel, imm5, A, B, ld_cc,
        input  result, valid, busy, n, z, p
    );

    modport slave (
        input  start, op, imm_sel, imm5, A, B, ld_cc,
        output result, valid, busy, n, z, p
    );
endinterface

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ADD/AND/NOT with registered result and N/Z/P codes.
// Define ALU_MUL_EN for an N-cycle shift-add MUL on op=11; otherwise op=11 is PASS.
module alu_exec #(
    parameter int unsigned N = 16
) (
    input logic       clk,
    input logic       reset,
    alu_exec_if.slave bus
);
    logic [N-1:0] op_b;
    logic [N-1:0] alu_res;
    logic [N-1:0] result_q, result_d;
    logic         valid_q, valid_d;
    logic [2:0]   nzp_q, nzp_d;

    function automatic logic [2:0] nzp_of(input logic [N-1:0] r);
        return {r[N-1], r == '0, !r[N-1] && (r != '0)};
    endfunction

    assign op_b = bus.imm_sel ? {{(N-5){bus.imm5[4]}}, bus.imm5} : bus.B;

    // op=11 yields A here; with MUL enabled this value is never selected
    always_comb begin
        unique case (bus.op)
            2'b00:   alu_res = bus.A + op_b;
            2'b01:   alu_res = bus.A & op_b;
            2'b10:   alu_res = ~bus.A;
            default: alu_res = bus.A;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {StIdle, StMul} state_e;
    localparam int unsigned CntW = $clog2(N);

    state_e          state_q, state_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    acc_next;
    logic [CntW-1:0] count_q, count_d;
    logic            ld_cc_q, ld_cc_d;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        ld_cc_d  = ld_cc_q;
        result_d = result_q;
        valid_d  = 1'b0;
        nzp_d    = nzp_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.op == 2'b11) begin
                        mcand_d  = bus.A;
                        mplier_d = op_b;
                        acc_d    = '0;
                        count_d  = '0;
                        ld_cc_d  = bus.ld_cc;
                        state_d  = StMul;
                    end else begin
                        result_d = alu_res;
                        valid_d  = 1'b1;
                        if (bus.ld_cc) nzp_d = nzp_of(alu_res);
                    end
                end
            end
            StMul: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CntW'(1);
                // Last iteration: always N edges, no early exit on zero multiplier
                if (count_q == CntW'(N - 1)) begin
                    result_d = acc_next;
                    valid_d  = 1'b1;
                    state_d  = StIdle;
                    if (ld_cc_q) nzp_d = nzp_of(acc_next);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            ld_cc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            ld_cc_q  <= ld_cc_d;
        end
    end

    assign bus.busy = (state_q == StMul);
`else
    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        nzp_d    = nzp_q;
        if (bus.start) begin
            result_d = alu_res;
            valid_d  = 1'b1;
            if (bus.ld_cc) nzp_d = nzp_of(alu_res);
        end
    end

    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            nzp_q    <= 3'b010;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
            nzp_q    <= nzp_d;
        end
    end

    assign bus.result = result_q;
    assign bus.valid  = valid_q;
    assign bus.n      = nzp_q[2];
    assign bus.z      = nzp_q[1];
    assign bus.p      = nzp_q[0];
endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver predicts each completion edge and value,
// a monitor checks result/valid/busy/nzp after every edge. Works with or without ALU_MUL_EN.
module tb_alu_exec;
    localparam int unsigned N = 16;

    typedef struct {
        int           ed;
        logic [N-1:0] res;
        logic [2:0]   nzp;
        logic         vld;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;

    ent_t sb[$];

    // Model state as seen by the driver
    logic [N-1:0] m_res;
    logic [2:0]   m_nzp;
    int           mul_start = 0;
    int           mul_end = 0;

    // Monitor's view of what the outputs should currently hold
    logic [N-1:0] cur_res = '0;
    logic [2:0]   cur_nzp = 3'b010;
    logic         exp_v;
    logic         exp_busy;
    ent_t         ent;

    alu_exec_if #(.N(N)) bus ();

    alu_exec #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", nm, edge_cnt, act, exp);
        end
    endtask

    function automatic logic [2:0] model_nzp(input logic [N-1:0] r);
        if ($signed(r) < 0) return 3'b100;
        if (r == 0) return 3'b010;
        return 3'b001;
    endfunction

    always @(posedge clk) begin
        #1;
        exp_v = 1'b0;
        if (sb.size() > 0 && sb[0].ed == edge_cnt) begin
            ent     = sb.pop_front();
            cur_res = ent.res;
            cur_nzp = ent.nzp;
            exp_v   = ent.vld;
        end
        exp_busy = (edge_cnt >= mul_start) && (edge_cnt < mul_end);
        check("valid", 32'(bus.valid), 32'(exp_v));
        check("result", 32'(bus.result), 32'(cur_res));
        check("nzp", 32'({bus.n, bus.z, bus.p}), 32'(cur_nzp));
        check("busy", 32'(bus.busy), 32'(exp_busy));
    end

    task automatic cycle(input logic rst, input logic st, input logic [1:0] o,
                         input logic isel, input logic [4:0] i5,
                         input logic [N-1:0] a, input logic [N-1:0] b, input logic lc);
        int           e;
        logic [N-1:0] opb;
        logic [N-1:0] r;
        logic [31:0]  prod;
        int           ce;
        @(negedge clk);
        e           = edge_cnt + 1;
        reset       = rst;
        bus.start   = st;
        bus.op      = o;
        bus.imm_sel = isel;
        bus.imm5    = i5;
        bus.A       = a;
        bus.B       = b;
        bus.ld_cc   = lc;
        if (!rst) begin
            sb.delete();
            m_res   = '0;
            m_nzp   = 3'b010;
            mul_end = 0;
            sb.push_back('{ed: e, res: '0, nzp: 3'b010, vld: 1'b0});
        end else if (st && e > mul_end) begin
            opb = isel ? N'($signed(i5)) : b;
            ce  = e;
            case (o)
                2'd0: r = a + opb;
                2'd1: r = a & opb;
                2'd2: r = ~a;
                default: begin
`ifdef ALU_MUL_EN
                    prod      = 32'(a) * 32'(opb);
                    r         = prod[N-1:0];
                    mul_start = e;
                    mul_end   = e + N;
                    ce        = e + N;
`else
                    r = a;
`endif
                end
            endcase
            m_res = r;
            if (lc) m_nzp = model_nzp(r);
            sb.push_back('{ed: ce, res: m_res, nzp: m_nzp, vld: 1'b1});
        end
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cycle(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, '0, '0, 1'b0);
    endtask

    initial begin
        reset       = 1'b0;
        bus.start   = 1'b1;
        bus.op      = 2'd0;
        bus.imm_sel = 1'b0;
        bus.imm5    = '0;
        bus.A       = '0;
        bus.B       = '0;
        bus.ld_cc   = 1'b0;
        m_res       = '0;
        m_nzp       = 3'b010;
        sb.push_back('{ed: 1, res: '0, nzp: 3'b010, vld: 1'b0});
        // Reset held with start asserted, then quiet idle
        @(posedge clk);
        cycle(1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 16'h1111, 16'h2222, 1'b1);
        idle(3);
        // ADD with negative immediate, then ADD without cc update
        cycle(1'b1, 1'b1, 2'd0, 1'b1, 5'h1E, 16'h0005, 16'h0000, 1'b1);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 5'h00, 16'h8000, 16'h8000, 1'b0);
        idle(1);
        // Back-to-back AND then NOT
        cycle(1'b1, 1'b1, 2'd1, 1'b0, 5'h00, 16'hF0F0, 16'h0FF0, 1'b1);
        cycle(1'b1, 1'b1, 2'd2, 1'b0, 5'h00, 16'h0000, 16'h1234, 1'b1);
        idle(1);
        // MUL (PASS without the feature) with a start attempt while busy
        cycle(1'b1, 1'b1, 2'd3, 1'b0, 5'h00, 16'h0007, 16'hFFFD, 1'b1);
        idle(3);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 5'h00, 16'h0001, 16'h0001, 1'b1);
        idle(14);
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 5'h00, 16'h0002, 16'h0003, 1'b1);
        idle(2);
        // MUL aborted by reset five edges after acceptance
        cycle(1'b1, 1'b1, 2'd3, 1'b0, 5'h00, 16'h0003, 16'h0004, 1'b1);
        idle(4);
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 5'h00, '0, '0, 1'b0);
        idle(20);
        // PASS / MUL on a distinct operand pair
        cycle(1'b1, 1'b1, 2'd3, 1'b0, 5'h00, 16'h1234, 16'hFFFF, 1'b1);
        idle(N + 2);
        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  5'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'h0000 : N'($urandom),
                  N'($urandom),
                  1'($urandom_range(0, 1)));
        end
        idle(N + 3);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
